reel_spin_gen: RTL

Parametrised multi-channel random "reel" generator for the slot-game datapath. Each of N_CH channels runs a maximal-length W-bit Galois LFSR. On a stop request the channels freeze one after another, STAGGER cycles apart. A one-cycle done pulse marks the end of the sequence, which then feeds scoring and display logic. This block supersedes the fixed four-channel, fixed-100-cycle generator with a configurable channel count, width and stagger, an explicit start/stop handshake and status outputs.

---
 rtl/reel_pkg.sv | 32 +++
 rtl/reel_lfsr.sv | 27 ++
 rtl/reel_spin_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/reel_pkg.sv
// Shared types and helpers for the staggered-stop reel generator:
// FSM states, per-width Galois tap table and per-channel seed function.
package reel_pkg;

  typedef enum logic [1:0] {IDLE, SPIN, STOPPING} state_e;

  // Right-shifting Galois taps for maximal-length polynomials, bit n-1 = x^n term.
  function automatic logic [15:0] tap_for(input int w);
    case (w)
      4:       tap_for = 16'h000C;
      5:       tap_for = 16'h0014;
      6:       tap_for = 16'h0030;
      7:       tap_for = 16'h0060;
      8:       tap_for = 16'h00B8;
      9:       tap_for = 16'h0110;
      10:      tap_for = 16'h0240;
      11:      tap_for = 16'h0500;
      12:      tap_for = 16'h0E08;
      13:      tap_for = 16'h1C80;
      14:      tap_for = 16'h3802;
      15:      tap_for = 16'h6000;
      16:      tap_for = 16'hD008;
      default: tap_for = 16'h000C;
    endcase
  endfunction

  // Seed lands in 1..2^w-1 so no channel can start in the all-zero lockup state.
  function automatic logic [15:0] seed_for(input int w, input int base, input int k);
    seed_for = 16'(((base + k) % ((1 << w) - 1)) + 1);
  endfunction

endpackage

// File: rtl/reel_lfsr.sv
// One reel channel: W-bit Galois LFSR that steps only while en is high.
module reel_lfsr #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   TAP  = 4'hC,
  parameter logic [W-1:0]   SEED = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] s_q, s_d;

  always_comb begin
    s_d = s_q;
    if (en) s_d = s_q[0] ? ((s_q >> 1) ^ TAP) : (s_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (!reset) s_q <= SEED;
    else        s_q <= s_d;
  end

  assign q = s_q;

endmodule

// File: rtl/reel_spin_gen.sv
// Multi-channel reel generator: start/stop handshake, staggered channel freeze, done pulse.
// Optional REEL_MATCH_EN builds an all-channels-equal flag registered with done.
module reel_spin_gen
  import reel_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int W         = 4,
  parameter int STAGGER   = 100,
  parameter int SEED_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [N_CH*W-1:0] rand_num,
  output logic [N_CH-1:0]   frozen,
  output logic              busy,
  output logic              done,
  output logic              match
);

  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [W-1:0] TAP_W = W'(tap_for(W));

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_CH-1:0]        frozen_q, frozen_d;
  logic                   done_q, done_d;
  logic                   tick, last, freeze_now, running;
  logic [N_CH-1:0][W-1:0] lane_q;

  assign tick       = (cnt_q == CW'(STAGGER - 1));
  assign last       = (idx_q == IW'(N_CH - 1));
  assign freeze_now = (state_q == STOPPING) && tick;
  assign running    = (state_q == SPIN) || (state_q == STOPPING);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      frozen_q <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frozen_q <= frozen_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frozen_d = frozen_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = SPIN;
        frozen_d = '0;
      end
      SPIN: if (stop) begin
        state_d = STOPPING;
        cnt_d   = '0;
        idx_d   = '0;
      end
      STOPPING: begin
        if (tick) begin
          frozen_d[idx_q] = 1'b1;
          idx_d           = idx_q + IW'(1);
          cnt_d           = '0;
          if (last) begin
            done_d  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // The freezing edge holds the lane, so the held value is the one seen the cycle before.
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic en;
    assign en = running && !frozen_q[k] && !(freeze_now && (idx_q == IW'(k)));
    reel_lfsr #(
      .W    (W),
      .TAP  (TAP_W),
      .SEED (W'(seed_for(W, SEED_BASE, k)))
    ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .q     (lane_q[k])
    );
  end

  assign rand_num = lane_q;
  assign frozen   = frozen_q;
  assign done     = done_q;

`ifdef REEL_MATCH_EN
  logic all_eq, match_q;

  always_comb begin
    all_eq = 1'b1;
    for (int k = 1; k < N_CH; k++)
      if (lane_q[k] != lane_q[0]) all_eq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) match_q <= 1'b0;
    else        match_q <= done_d && all_eq;
  end

  assign match = match_q;
`else
  assign match = 1'b0;
`endif

endmodule
